msk_state_loader: RTL and testbench
===================================

MSK_STATE_LOADER -- requirements
Module: msk_state_loader

Interface
REQ-001 Parameter d, default 2: number of shares per masked bit.
REQ-002 Parameter ncols, default 4: number of 32-bit columns in the downstream scan chain; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 in_valid  input  1  upstream column beat valid.
REQ-006 in_ready  output  1  loader accepts an input beat.
REQ-007 in_data  input  32*d  masked input column, share-interleaved as for the chain.
REQ-008 core_start  output  1  one-cycle pulse: state loaded, core may begin.
REQ-009 core_en  input  1  datapath enable requested by the round controller.
REQ-010 core_done  input  1  core finished; state ready for unload.
REQ-011 col_in  input  32*d  tail column (out_q of the last chain stage).
REQ-012 out_valid  output  1  output column valid.
REQ-013 out_ready  input  1  downstream accepts an output column.
REQ-014 out_data  output  32*d  masked output column.
REQ-015 scan_en  output  1  chain mux select (1 = shift scan data).
REQ-016 reg_en  output  1  chain register enable.
REQ-017 scan_data  output  32*d  data driven into the chain head scan input.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD, RUN and UNLOAD, and a beat counter of log2(ncols) bits.
REQ-020 in_ready SHALL be 1 in IDLE and LOAD and 0 otherwise; an input beat is accepted when in_valid and in_ready are both 1.
REQ-021 On an accepted input beat: scan_en=1, reg_en=1, scan_data=in_data (same cycle, combinational); the counter increments; an IDLE beat moves the FSM to LOAD.
REQ-022 On an accepted beat with counter==ncols-1: the counter wraps to 0 and the FSM enters RUN; core_start SHALL be 1 in the first RUN cycle only.
REQ-023 In IDLE or LOAD with no accepted beat: reg_en=0, scan_en=0, and the counter holds; a stall in LOAD SHALL NOT lose its position.
REQ-024 In RUN: scan_en=0, reg_en=core_en, in_ready=0, out_valid=0.
REQ-025 core_done=1 in RUN SHALL move the FSM to UNLOAD on the next edge; core_done and core_en SHALL be ignored in every other state (reg_en is not driven by core_en outside RUN).
REQ-026 In UNLOAD: out_valid=1 and out_data=col_in combinationally.
REQ-027 On out_valid and out_ready in UNLOAD: scan_en=1, reg_en=1, scan_data=0, and the counter increments.
REQ-028 In UNLOAD, the handshake with counter==ncols-1 SHALL wrap the counter to 0 and return the FSM to IDLE.
REQ-029 scan_data SHALL be all-zero whenever no input beat is being accepted.
REQ-030 Shares SHALL only be routed, never combined: no logic gate takes bits of two different shares of the same bit.
REQ-031 out_data SHALL be 0 when out_valid=0.
REQ-032 Simultaneous in_valid in RUN or UNLOAD SHALL be ignored (not accepted, no state change).

Reset
REQ-033 With rst=1 at an edge: FSM enters IDLE and the counter becomes 0.
REQ-034 While rst=1: in_ready=0, out_valid=0, core_start=0, scan_en=0, reg_en=0, busy=0.
REQ-035 Reset asserted mid-LOAD or mid-UNLOAD SHALL discard partial progress; the next load starts at beat 0.

Verification
REQ-036 d=2, ncols=4: four back-to-back beats A0..A3 with in_valid=1 -> scan_en=reg_en=1 for 4 cycles with scan_data=Ai; core_start is a single pulse in the next cycle; busy=1.
REQ-037 Load with in_valid deasserted for 3 cycles after beat 1 -> reg_en=0 during the gap; RUN is entered only after the 4th accepted beat.
REQ-038 In RUN, toggle core_en 1,0,1 and drive in_valid=1 -> reg_en follows core_en, scan_en=0, in_ready=0, no beat accepted.
REQ-039 core_done pulse, then out_ready low for 2 cycles, then high -> out_valid=1 throughout with out_data=col_in; 4 handshakes with scan_data=0; IDLE with busy=0 afterwards.
REQ-040 rst pulse after 2 load beats, then 4 fresh beats -> core_start occurs only after the 4 fresh beats.
REQ-041 core_done asserted in IDLE -> no transition, out_valid stays 0.

Source files
------------

// File: rtl/msk_state_loader_if.sv
// Upstream/downstream column handshakes of the masked state loader.
// Data is share-interleaved, 32 bits per share.
interface msk_state_loader_if #(
    parameter int d = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [32*d-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [32*d-1:0]   out_data;

    // master is the producer of input beats and consumer of output columns
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/msk_state_loader.sv
// Loads a masked state column-by-column into a scan chain, hands it to the core,
// then unloads it column-by-column. Shares are only routed, never combined.
module msk_state_loader #(
    parameter int d     = 2,
    parameter int ncols = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    msk_state_loader_if.slave    bus,
    output logic                 core_start,
    input  logic                 core_en,
    input  logic                 core_done,
    input  logic [32*d-1:0]      col_in,
    output logic                 scan_en,
    output logic                 reg_en,
    output logic [32*d-1:0]      scan_data,
    output logic                 busy
);
    localparam int W  = 32 * d;
    localparam int CW = $clog2(ncols);
    localparam logic [CW-1:0] LAST = CW'(ncols - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;

    state_t         state, next_state;
    logic [CW-1:0]  cnt, cnt_next;
    logic           first_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            first_run <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            first_run <= (state != RUN) && (next_state == RUN);
        end
    end

    // All outputs are forced quiet while rst is high, regardless of state.
    always_comb begin
        next_state    = state;
        cnt_next      = cnt;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        scan_en       = 1'b0;
        reg_en        = 1'b0;
        scan_data     = '0;
        core_start    = 1'b0;
        busy          = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                IDLE, LOAD: begin
                    bus.in_ready = 1'b1;
                    if (bus.in_valid) begin
                        scan_en   = 1'b1;
                        reg_en    = 1'b1;
                        scan_data = bus.in_data;
                        cnt_next  = cnt + CW'(1);
                        next_state = (cnt == LAST) ? RUN : LOAD;
                    end
                end
                RUN: begin
                    reg_en     = core_en;
                    core_start = first_run;
                    if (core_done) begin
                        next_state = UNLOAD;
                    end
                end
                UNLOAD: begin
                    bus.out_valid = 1'b1;
                    bus.out_data  = col_in;
                    if (bus.out_ready) begin
                        scan_en  = 1'b1;
                        reg_en   = 1'b1;
                        cnt_next = cnt + CW'(1);
                        if (cnt == LAST) begin
                            next_state = IDLE;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    logic [W-1:0] unused_width_check;
    assign unused_width_check = '0;
endmodule

// File: tb/tb_msk_state_loader.sv
// Directed self-checking bench for msk_state_loader with d=2, ncols=4.
module tb_msk_state_loader;
    localparam int D = 2;
    localparam int N = 4;
    localparam int W = 32 * D;

    logic          clk;
    logic          rst;
    logic          core_en;
    logic          core_done;
    logic [W-1:0]  col_in;
    logic          core_start;
    logic          scan_en;
    logic          reg_en;
    logic [W-1:0]  scan_data;
    logic          busy;

    int n_checks;
    int n_pass;

    msk_state_loader_if #(.d(D)) bus ();

    msk_state_loader #(.d(D), .ncols(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .core_start (core_start),
        .core_en    (core_en),
        .core_done  (core_done),
        .col_in     (col_in),
        .scan_en    (scan_en),
        .reg_en     (reg_en),
        .scan_data  (scan_data),
        .busy       (busy)
    );

    // Flag order: in_ready, scan_en, reg_en, core_start, out_valid, busy
    logic [5:0] obs;
    assign obs = {bus.in_ready, scan_en, reg_en, core_start, bus.out_valid, busy};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [W-1:0] beats [4];
    initial begin
        beats[0] = 64'h0123_4567_89AB_CDEF;
        beats[1] = 64'hDEAD_BEEF_CAFE_F00D;
        beats[2] = 64'hFFFF_0000_A5A5_5A5A;
        beats[3] = 64'h8000_0001_7FFF_FFFE;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = beats[0];
        bus.out_ready = 1'b1; core_done = 1'b1; core_en = 1'b1;
        col_in = 64'h1111_2222_3333_4444;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs !== 6'b000000) $display("[TB] FAIL reset_flags[%0d]: got %b want %b", k, obs, 6'b000000);
            else n_pass++;
            n_checks++;
            if (scan_data !== '0 || bus.out_data !== '0)
                $display("[TB] FAIL reset_data[%0d]: got scan %h out %h want 0", k, scan_data, bus.out_data);
            else n_pass++;
            step();
        end
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; core_done = 1'b0; core_en = 1'b0;
        #1;
        n_checks++;
        if (obs !== 6'b100000) $display("[TB] FAIL reset_idle: got %b want %b", obs, 6'b100000);
        else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        for (int i = 0; i < N; i++) begin
            bus.in_valid = 1'b1; bus.in_data = beats[i];
            #1;
            exp = {5'b11100, (i != 0)};
            n_checks++;
            if (obs !== exp) $display("[TB] FAIL b2b_flags[%0d]: got %b want %b", i, obs, exp);
            else n_pass++;
            n_checks++;
            if (scan_data !== beats[i]) $display("[TB] FAIL b2b_scan[%0d]: got %h want %h", i, scan_data, beats[i]);
            else n_pass++;
            step();
        end
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (obs !== 6'b000101) $display("[TB] FAIL b2b_start: got %b want %b", obs, 6'b000101);
        else n_pass++;
        step();
    endtask

    task automatic test_run_gating();
        logic [2:0] ce_pat;
        logic [5:0] exp;
        ce_pat = 3'b101;
        bus.in_valid = 1'b1; bus.in_data = beats[2];
        col_in = 64'hAAAA_BBBB_CCCC_DDDD;
        for (int i = 0; i < 3; i++) begin
            core_en = ce_pat[2-i];
            #1;
            exp = {2'b00, ce_pat[2-i], 3'b001};
            n_checks++;
            if (obs !== exp) $display("[TB] FAIL run_flags[%0d]: got %b want %b", i, obs, exp);
            else n_pass++;
            n_checks++;
            if (scan_data !== '0 || bus.out_data !== '0)
                $display("[TB] FAIL run_data[%0d]: got scan %h out %h want 0", i, scan_data, bus.out_data);
            else n_pass++;
            step();
        end
        bus.in_valid = 1'b0; core_en = 1'b0;
    endtask

    task automatic test_unload();
        logic [W-1:0] c;
        core_done = 1'b1;
        #1;
        n_checks++;
        if (obs !== 6'b000001) $display("[TB] FAIL unload_done: got %b want %b", obs, 6'b000001);
        else n_pass++;
        step();
        core_done = 1'b0; bus.in_valid = 1'b1; bus.in_data = beats[1];
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            c = {32'h5000_0000 + 32'(k), 32'h0000_00A0 + 32'(k)};
            col_in = c;
            #1;
            n_checks++;
            if (obs !== 6'b000011) $display("[TB] FAIL unload_stall_flags[%0d]: got %b want %b", k, obs, 6'b000011);
            else n_pass++;
            n_checks++;
            if (bus.out_data !== c || scan_data !== '0)
                $display("[TB] FAIL unload_stall_data[%0d]: got out %h scan %h want out %h scan 0", k, bus.out_data, scan_data, c);
            else n_pass++;
            step();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            c = {32'hC0DE_0000 + 32'(k), ~(32'h1 << k)};
            col_in = c;
            #1;
            n_checks++;
            if (obs !== 6'b011011) $display("[TB] FAIL unload_hs_flags[%0d]: got %b want %b", k, obs, 6'b011011);
            else n_pass++;
            n_checks++;
            if (bus.out_data !== c || scan_data !== '0)
                $display("[TB] FAIL unload_hs_data[%0d]: got out %h scan %h want out %h scan 0", k, bus.out_data, scan_data, c);
            else n_pass++;
            step();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        n_checks++;
        if (obs !== 6'b100000 || bus.out_data !== '0)
            $display("[TB] FAIL unload_idle: got %b out %h want %b out 0", obs, bus.out_data, 6'b100000);
        else n_pass++;
        step();
    endtask

    task automatic test_idle_core_done();
        core_done = 1'b1; core_en = 1'b1; bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (obs !== 6'b100000 || bus.out_data !== '0)
                $display("[TB] FAIL idle_done[%0d]: got %b out %h want %b out 0", k, obs, bus.out_data, 6'b100000);
            else n_pass++;
            step();
        end
        core_done = 1'b0; core_en = 1'b0; bus.out_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [5:0] exp;
        int b;
        b = 0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = (i < 2 || i > 4);
            bus.in_data  = beats[b];
            #1;
            exp = bus.in_valid ? {5'b11100, (i != 0)} : 6'b100001;
            n_checks++;
            if (obs !== exp) $display("[TB] FAIL stall_flags[%0d]: got %b want %b", i, obs, exp);
            else n_pass++;
            n_checks++;
            if (scan_data !== (bus.in_valid ? beats[b] : '0))
                $display("[TB] FAIL stall_scan[%0d]: got %h", i, scan_data);
            else n_pass++;
            if (bus.in_valid) b++;
            step();
        end
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (obs !== 6'b000101) $display("[TB] FAIL stall_start: got %b want %b", obs, 6'b000101);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_load();
        logic [5:0] exp;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1; bus.in_data = beats[i];
            step();
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 6'b000000 || scan_data !== '0)
            $display("[TB] FAIL midload_rst: got %b scan %h want 000000 scan 0", obs, scan_data);
        else n_pass++;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.in_data = beats[3-i];
            #1;
            exp = {5'b11100, (i != 0)};
            n_checks++;
            if (obs !== exp) $display("[TB] FAIL fresh_flags[%0d]: got %b want %b", i, obs, exp);
            else n_pass++;
            step();
        end
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (obs !== 6'b000101) $display("[TB] FAIL fresh_start: got %b want %b", obs, 6'b000101);
        else n_pass++;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; core_en = 1'b0; core_done = 1'b0; col_in = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_run_gating();
        test_unload();
        test_idle_core_done();
        test_stall();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
